// File: rtl/instr_fetch_unit.sv
// Instruction fetch (IF) stage: issues sequential PC fetches to instruction
// memory, tracks in-flight requests in a tag queue, buffers responses in a
// prefetch FIFO and hands {instruction, PC, fields} to decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets
// raise a sticky FetchFaultF and block issue until an aligned redirect.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        InstrValidD,
    input  logic        InstrReadyD,
    output logic [31:0] InstrD,
    output logic [31:0] PcD,
    output logic [6:0]  OpD,
    output logic [2:0]  Fn3D,
    output logic [6:0]  Fn7D,
    output logic        FetchFaultF
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]                pc;
    logic [31:0]                target_load;
    logic                       issue_en;
    logic                       fault;
    logic                       accept;
    logic                       rsp_keep;
    logic                       fifo_pop;

    logic [31:0]                tag_pc   [MAX_OUTSTANDING];
    logic [31:0]                tag_pc_n [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] tag_kill;
    logic [MAX_OUTSTANDING-1:0] tag_kill_n;
    logic [TW-1:0]              tag_cnt;
    logic [TW-1:0]              tag_cnt_n;
    logic [TW-1:0]              push_idx;

    logic [31:0]                fifo_pc   [FIFO_DEPTH];
    logic [31:0]                fifo_data [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              fifo_cnt;

    // Request credit: one slot per outstanding request and per buffered word.
    always_comb begin
        ImemReqValid = issue_en && !fault && !Redirect
                       && (tag_cnt < TW'(MAX_OUTSTANDING))
                       && ((32'(fifo_cnt) + 32'(tag_cnt)) < FIFO_DEPTH);
        ImemReqAddr  = pc;
        accept       = ImemReqValid && ImemReqReady;
        rsp_keep     = ImemRspValid && !tag_kill[0] && !Redirect;
        fifo_pop     = InstrValidD && InstrReadyD && !Redirect;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_load = RedirectTarget;

    // Sticky misaligned-target fault, re-evaluated on every redirect.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N)    fault <= 1'b0;
        else if (Redirect) fault <= |RedirectTarget[1:0];
    end
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^RedirectTarget[1:0];
    assign target_load       = {RedirectTarget[31:2], 2'b00};
    assign fault             = 1'b0;
`endif

    assign FetchFaultF = fault;

    // PC register and issue enable (issue starts one cycle after reset release).
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            pc       <= RESET_PC;
            issue_en <= 1'b0;
        end else begin
            issue_en <= 1'b1;
            if (Redirect)    pc <= target_load;
            else if (accept) pc <= pc + 32'd4;
        end
    end

    // Tag queue next state: slot 0 is the oldest request; a response shifts
    // the queue down, so a same-cycle push lands one slot lower.
    always_comb begin
        tag_pc_n   = tag_pc;
        tag_kill_n = tag_kill;
        tag_cnt_n  = tag_cnt;
        push_idx   = tag_cnt;
        if (ImemRspValid && tag_cnt != '0) begin
            for (int unsigned i = 0; i + 1 < MAX_OUTSTANDING; i++) begin
                tag_pc_n[i]   = tag_pc[i+1];
                tag_kill_n[i] = tag_kill[i+1];
            end
            tag_kill_n[MAX_OUTSTANDING-1] = 1'b1;
            tag_cnt_n = tag_cnt - TW'(1);
            push_idx  = tag_cnt - TW'(1);
        end
        if (accept) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (TW'(i) == push_idx) begin
                    tag_pc_n[i]   = pc;
                    tag_kill_n[i] = 1'b0;
                end
            end
            tag_cnt_n = tag_cnt_n + TW'(1);
        end
        if (Redirect) tag_kill_n = '1;
    end

    // Tag queue control state.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            tag_cnt  <= '0;
            tag_kill <= '1;
        end else begin
            tag_cnt  <= tag_cnt_n;
            tag_kill <= tag_kill_n;
        end
    end

    // Tag queue PC storage (no reset needed, qualified by tag_cnt).
    always_ff @(posedge CPU_CLK) begin
        tag_pc <= tag_pc_n;
    end

    // Prefetch FIFO storage.
    always_ff @(posedge CPU_CLK) begin
        if (rsp_keep) begin
            fifo_pc[wr_ptr]   <= tag_pc[0];
            fifo_data[wr_ptr] <= ImemRspData;
        end
    end

    // Prefetch FIFO pointers and occupancy; redirect flushes everything.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (Redirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rsp_keep) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({rsp_keep, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Decode-side outputs: NOP and PC 0 whenever nothing is valid.
    always_comb begin
        InstrValidD = (fifo_cnt != '0);
        InstrD      = InstrValidD ? fifo_data[rd_ptr] : NOP;
        PcD         = InstrValidD ? fifo_pc[rd_ptr] : '0;
        OpD         = InstrD[6:0];
        Fn3D        = InstrD[14:12];
        Fn7D        = InstrD[31:25];
    end

    rsp_has_tag: assert property (@(posedge CPU_CLK) disable iff (!CPU_RST_N)
        ImemRspValid |-> (tag_cnt != '0));

endmodule
